mips_cpu_pc_sequencer: RTL
==========================

# mips_cpu_pc_sequencer

Owns the program counter and the CPU's FETCH/EXEC sequencing: it steps the core through instruction fetch, execute and load-writeback cycles, honours memory `waitrequest`, and applies jump/branch targets after the branch delay slot. It consumes the 2-bit jump-selection encoding produced by branch decode. It drives the `state` and `stall` signals consumed by branch control, register write-enable and the memory interface.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000: PC value after reset.
- `HALT_ADDR`, default 32'h00000000: jumping here halts the CPU.

- `clk`  in  1  rising-edge clock; only clock.
- `reset`  in  1  synchronous, active-high reset.
- `waitrequest`  in  1  memory busy; stalls the current memory phase.
- `is_load`  in  1  EXEC instruction is a load (needs a writeback cycle).
- `is_store`  in  1  EXEC instruction is a store.
- `jump_sel`  in  2  valid in EXEC: 00 none, 01 absolute (rs), 10 page absolute, 11 PC-relative.
- `rs_value`  in  32  register rs, for the absolute target.
- `instr_index`  in  26  instruction[25:0], for the page target.
- `imm16`  in  16  instruction[15:0], for the relative offset.
- `pc`  out  32  current instruction address.
- `pc_plus_8`  out  32  `pc + 8`, the link value.
- `state`  out  1  0 = FETCH, 1 = EXEC or LOAD_WB.
- `stall`  out  1  high only in LOAD_WB.
- `instr_fetch`  out  1  high in FETCH while active; the instruction read address is `pc`.
- `active`  out  1  low once halted.

## Operation
- Internal FSM states: FETCH, EXEC, LOAD_WB, HALTED. There is also a `pending` flag with a 32-bit `pending_target` register.
- FETCH:
  - `waitrequest` high: stay in FETCH.
  - otherwise: go to EXEC.
- EXEC:
  - `(is_load|is_store) && waitrequest`: stay in EXEC.
  - else `is_load`: go to LOAD_WB.
  - else: go to FETCH and perform the PC update.
- LOAD_WB:
  - `waitrequest` high: stay in LOAD_WB.
  - otherwise: go to FETCH and perform the PC update.
- Target computation uses the EXEC-time `pc` (P):
  - 01: `rs_value`.
  - 10: `{(P+4)[31:28], instr_index, 2'b00}`.
  - 11: `P + 4 + (sign_extend(imm16) << 2)`, modulo 2^32.
- PC update at instruction retire:
  - If `pending` is 1: `pc <= pending_target` and clear `pending`. The retiring instruction is the delay slot.
  - Else if `jump_sel != 00`: `pending_target <=` target, `pending <= 1`, `pc <= P+4`.
  - Else: `pc <= P+4`.
- A branch in a delay slot is ignored. `pending` already set takes priority and the slot's `jump_sel` is discarded.
- Halt: if a retire would load `pc` from `pending_target == HALT_ADDR`:
  - `pc <= HALT_ADDR`, go to HALTED, `active <= 0`.
  - HALTED ignores all inputs until `reset`. In HALTED, `instr_fetch = 0`, `state = 0` and `stall = 0`.
- `jump_sel`, `rs_value`, `instr_index` and `imm16` are sampled only on the retiring EXEC edge. They are don't-care in other states.
- Alignment is not checked. Non-word-aligned targets pass through unchanged.

## Timing
- Reset values (output/register, value): `pc` RESET_VECTOR; FSM FETCH; `pending` 0; `pending_target` 0; `state` 0; `stall` 0; `instr_fetch` 1; `active` 1.
- `pc_plus_8` is combinational from `pc`.
- `state`, `stall` and `instr_fetch` are decoded combinationally from the FSM register.
- Minimum latency per instruction:
  - non-load: 2 cycles (FETCH, EXEC).
  - load: 3 cycles (FETCH, EXEC, LOAD_WB).
  - Each `waitrequest`-high cycle adds one cycle.
- A taken jump retired at edge N:
  - the delay slot at P+4 is fetched in the next FETCH.
  - the target is fetched after the delay slot retires.
  - no instruction after P+4 is fetched on the fall-through path.
- Reset asserted in any state, including mid-stall or with `pending` set, restores all reset values on that edge. The pending target is lost.
- `reset` has priority over every transition and over `waitrequest`.

## Test plan
- Reset, then 4 NOPs with `waitrequest` = 0:
  - `pc` sequence BFC00000, BFC00004, BFC00008, BFC0000C.
  - `state` alternates 0,1 every cycle.
  - `stall` stays 0.
- BEQ-style `jump_sel` = 11, `imm16` = 16'hFFFE at `pc` BFC00010:
  - the next instruction is at BFC00014 (delay slot).
  - the one after that is at BFC0000C.
- JR with `rs_value` = 0 at BFC00020, delay slot NOP:
  - after the slot retires, `pc` = 0, `active` = 0 and `instr_fetch` = 0.
  - all outputs are stable for 10 further cycles.
- Load with `waitrequest` high for 2 cycles in EXEC and 1 cycle in LOAD_WB:
  - instruction takes 6 cycles.
  - `stall` = 1 for exactly 2 cycles.
  - `pc` advances by 4 once.
- J with `instr_index` = 26'h0000100 at BFC00000, with a second J in the delay slot:
  - `pc` goes BFC00000, BFC00004, B0000400.
  - the second J is ignored.
- `reset` asserted while `pending` = 1 and in LOAD_WB:
  - the next cycle has `pc` = BFC00000, `state` = 0 and `pending` = 0.
  - no jump is taken afterwards.

Source files
------------

// File: rtl/mips_cpu_pc_sequencer.sv
// Program counter and FETCH/EXEC/LOAD_WB sequencing with one branch delay slot.
module mips_cpu_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] rs_value,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_8,
  output logic        state,
  output logic        stall,
  output logic        instr_fetch,
  output logic        active
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_LOAD_WB = 2'd2,
    S_HALTED  = 2'd3
  } seq_state_e;

  seq_state_e    fsm_q, fsm_d;
  logic [AW-1:0] pc_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] pending_target_q, pending_target_d;
  logic          active_d;
  logic [AW-1:0] pc_plus_4;
  logic [AW-1:0] rel_offset;
  logic [AW-1:0] jump_target;
  logic          retire;
  logic          retire_exec;

  // Jump target candidates, all relative to the EXEC-time pc.
  always_comb begin
    pc_plus_4  = pc + AW'(4);
    rel_offset = {{14{imm16[15]}}, imm16, 2'b00};
    unique case (jump_sel)
      2'b01:   jump_target = rs_value;
      2'b10:   jump_target = {pc_plus_4[31:28], instr_index, 2'b00};
      2'b11:   jump_target = pc_plus_4 + rel_offset;
      default: jump_target = pc_plus_4;
    endcase
  end

  // Next-state sequencing and retire-time pc / delay-slot bookkeeping.
  always_comb begin
    fsm_d            = fsm_q;
    pc_d             = pc;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    active_d         = active;
    retire           = 1'b0;
    retire_exec      = 1'b0;

    unique case (fsm_q)
      S_FETCH: begin
        if (!waitrequest) fsm_d = S_EXEC;
      end
      S_EXEC: begin
        if ((is_load || is_store) && waitrequest) begin
          fsm_d = S_EXEC;
        end else if (is_load) begin
          fsm_d = S_LOAD_WB;
        end else begin
          fsm_d       = S_FETCH;
          retire      = 1'b1;
          retire_exec = 1'b1;
        end
      end
      S_LOAD_WB: begin
        if (!waitrequest) begin
          fsm_d  = S_FETCH;
          retire = 1'b1;
        end
      end
      default: fsm_d = S_HALTED;
    endcase

    if (retire) begin
      if (pending_q) begin
        // Delay slot retiring: redirect to the saved target; a slot branch is dropped.
        pending_d = 1'b0;
        pc_d      = pending_target_q;
        if (pending_target_q == HALT_ADDR) begin
          fsm_d    = S_HALTED;
          active_d = 1'b0;
        end
      end else begin
        pc_d = pc_plus_4;
        if (retire_exec && (jump_sel != 2'b00)) begin
          pending_d        = 1'b1;
          pending_target_d = jump_target;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q            <= S_FETCH;
      pc               <= RESET_VECTOR;
      pending_q        <= 1'b0;
      pending_target_q <= '0;
      active           <= 1'b1;
    end else begin
      fsm_q            <= fsm_d;
      pc               <= pc_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
      active           <= active_d;
    end
  end

  // Status decode from the state register.
  always_comb begin
    pc_plus_8   = pc + AW'(8);
    state       = (fsm_q == S_EXEC) || (fsm_q == S_LOAD_WB);
    stall       = (fsm_q == S_LOAD_WB);
    instr_fetch = (fsm_q == S_FETCH);
  end

endmodule
